// File: rtl/gps_sched_pkg.sv
// Shared types and width constants for the GPS satellite scheduler.
package gps_sched_pkg;

    localparam int NSAT_DEFAULT = 4;
    localparam int FREQ_W       = 32;
    localparam int GAIN_W       = 16;
    localparam int CASEL_W      = 6;
    localparam int CNT_W        = 16;

    // Commit sequencer state.
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } sched_state_e;

endpackage

// File: rtl/gps_epoch_timer.sv
// Epoch timer: free-running cycle counter that wraps every epoch_len + 1
// cycles while run is high and emits a registered one-cycle epoch_tick.
module gps_epoch_timer #(
    parameter int EPOCH_W = 32
) (
    input  logic               axi_aclk,
    input  logic               axi_aresetn,
    input  logic               run,
    input  logic [EPOCH_W-1:0] epoch_len,
    output logic               epoch_tick,
    output logic [31:0]        epoch_cnt
);

    logic [EPOCH_W-1:0] cnt;

    // Count cycles inside the epoch; >= lets a shrunken epoch_len wrap at once.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cnt        <= '0;
            epoch_tick <= 1'b0;
            epoch_cnt  <= '0;
        end else if (!run) begin
            cnt        <= '0;
            epoch_tick <= 1'b0;
            epoch_cnt  <= '0;
        end else if (cnt >= epoch_len) begin
            cnt        <= '0;
            epoch_tick <= 1'b1;
            epoch_cnt  <= epoch_cnt + 32'd1;
        end else begin
            cnt        <= cnt + 1'b1;
            epoch_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/gps_sat_scheduler.sv
// Satellite parameter scheduler: arms a commit of the shadow registers and
// applies every satellite atomically on the next epoch boundary.
// Optional per-epoch Doppler ramp is enabled by defining SAT_RAMP_EN.
module gps_sat_scheduler
    import gps_sched_pkg::*;
#(
    parameter int NSAT    = NSAT_DEFAULT,
    parameter int EPOCH_W = 32,
    parameter int RATE_W  = 32
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    input  logic                            run,
    input  logic [EPOCH_W-1:0]              epoch_len,
    input  logic                            commit_req,
    input  logic                            commit_abort,
    input  logic [NSAT-1:0][FREQ_W-1:0]     shd_freq,
    input  logic [NSAT-1:0][GAIN_W-1:0]     shd_gain,
    input  logic [NSAT-1:0][CASEL_W-1:0]    shd_ca_sel,
    input  logic [NSAT-1:0][RATE_W-1:0]     shd_rate,
    output logic                            gps_enable,
    output logic [NSAT-1:0][FREQ_W-1:0]     freq,
    output logic [NSAT-1:0][GAIN_W-1:0]     gain,
    output logic [NSAT-1:0][CASEL_W-1:0]    ca_sel,
    output logic                            epoch_tick,
    output logic [31:0]                     epoch_cnt,
    output logic                            commit_busy,
    output logic [CNT_W-1:0]                commit_cnt,
    output logic                            commit_ovr
);

    sched_state_e state;
    logic         primed;
    logic         apply;

    gps_epoch_timer #(
        .EPOCH_W (EPOCH_W)
    ) u_timer (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .run         (run),
        .epoch_len   (epoch_len),
        .epoch_tick  (epoch_tick),
        .epoch_cnt   (epoch_cnt)
    );

    // An armed commit lands on the tick edge unless aborted in that cycle.
    assign apply = (state == ARMED) && epoch_tick && !commit_abort;

`ifdef SAT_RAMP_EN
    logic [NSAT-1:0][RATE_W-1:0] rate;

    // Rate registers follow the shadow rates only when a commit lands.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rate <= '0;
        end else if (apply) begin
            rate <= shd_rate;
        end
    end
`else
    logic unused_rate;
    assign unused_rate = ^shd_rate;
`endif

    // Commit FSM plus live parameter registers; enable looks ahead at apply
    // so it rises in the same cycle the first parameters become visible.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state       <= IDLE;
            primed      <= 1'b0;
            gps_enable  <= 1'b0;
            freq        <= '0;
            gain        <= '0;
            ca_sel      <= '0;
            commit_busy <= 1'b0;
            commit_cnt  <= '0;
            commit_ovr  <= 1'b0;
        end else begin
            gps_enable <= run & (primed | apply);

            case (state)
                IDLE: begin
                    if (commit_req) begin
                        state       <= ARMED;
                        commit_busy <= 1'b1;
                    end
                end
                ARMED: begin
                    if (commit_req) begin
                        commit_ovr <= 1'b1;
                    end
                    if (commit_abort || epoch_tick) begin
                        state       <= IDLE;
                        commit_busy <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    commit_busy <= 1'b0;
                end
            endcase

            if (apply) begin
                freq       <= shd_freq;
                gain       <= shd_gain;
                ca_sel     <= shd_ca_sel;
                primed     <= 1'b1;
                commit_cnt <= commit_cnt + 1'b1;
            end
`ifdef SAT_RAMP_EN
            else if (epoch_tick && primed) begin
                for (int i = 0; i < NSAT; i++) begin
                    freq[i] <= freq[i] + FREQ_W'(signed'(rate[i]));
                end
            end
`endif
        end
    end

endmodule

// File: doc/gps_sat_scheduler.md
Name: gps_sat_scheduler

Overview:
- Sequencing controller between the AXI register file and the GPS emulator datapath.
- Software writes satellite parameters into shadow registers and then issues a commit. The block applies all satellites atomically on the next epoch boundary, so the emulator never sees a half-updated constellation.
- Generates the emulator enable signal.
- Optionally ramps each satellite's Doppler frequency once per epoch.

Parameters:
NSAT, 4, number of satellite channels
EPOCH_W, 32, width of the epoch length and epoch counter
RATE_W, 32, width of the signed per-epoch frequency increment

Ports:
axi_aclk  in  1  system clock, same clock as the regfile and emulator
axi_aresetn  in  1  asynchronous active-low reset
run  in  1  level; enables the epoch timer and, once primed, the emulator
epoch_len  in  EPOCH_W  epoch period minus 1, in cycles (99999 = 1 ms at 100 MHz)
commit_req  in  1  one-cycle pulse: arm a commit of the shadow values
commit_abort  in  1  one-cycle pulse: cancel an armed commit
shd_freq  in  NSAT x 32  shadow Doppler phase increment per satellite
shd_gain  in  NSAT x 16  shadow gain
shd_ca_sel  in  NSAT x 6  shadow C/A select, 0-35
shd_rate  in  NSAT x RATE_W  signed frequency increment per epoch
gps_enable  out  1  emulator enable
freq  out  NSAT x 32  live frequency to the emulator
gain  out  NSAT x 16  live gain
ca_sel  out  NSAT x 6  live C/A select
epoch_tick  out  1  one-cycle pulse at each epoch boundary
epoch_cnt  out  32  epochs elapsed since run rose, wrapping
commit_busy  out  1  high while a commit is armed
commit_cnt  out  16  completed commits, wrapping
commit_ovr  out  1  sticky: a commit_req arrived while already armed; cleared only by reset

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, FSM in IDLE, primed = 0, timer = 0.
- Epoch timer:
  - While run = 1: cnt increments each cycle. When cnt >= epoch_len, cnt <= 0 and epoch_tick is asserted (registered) in the next cycle.
  - Tick period is epoch_len + 1 cycles. The first tick occurs epoch_len + 1 cycles after run rises. epoch_len = 0 gives a tick every cycle.
  - The >= compare means shrinking epoch_len below the current cnt forces an immediate wrap.
  - While run = 0: cnt held at 0, epoch_tick = 0, epoch_cnt cleared to 0.
  - epoch_cnt increments on each tick and wraps mod 2^32.
- FSM states:
  - IDLE: commit_req -> ARMED. commit_abort is ignored.
  - ARMED: commit_busy = 1.
    - commit_abort -> IDLE; outputs unchanged, commit_cnt unchanged.
    - On the edge where epoch_tick = 1:
      - freq/gain/ca_sel <= shd_* for all satellites in the same edge.
      - Internal rate registers <= shd_rate.
      - primed <= 1, commit_cnt++, -> IDLE.
    - commit_req while ARMED: ignored (no re-arm), commit_ovr <= 1.
    - commit_abort and epoch_tick in the same cycle: abort wins, nothing applied.
- Timing and latency:
  - commit_req in the same cycle as epoch_tick while IDLE arms only; it applies on the following tick, never the same cycle.
  - Shadow values are sampled on the tick edge; changes to shd_* after commit_req and before the tick are taken.
  - New values are visible in the cycle after epoch_tick.
- gps_enable: registered, equal to run & primed.
  - Falls one cycle after run falls.
  - Live parameters and primed are retained while run = 0.
- run = 0 while ARMED: stays ARMED, since no ticks occur. The commit applies at the first tick after run returns.
- Arithmetic: freq is a phase increment; addition wraps mod 2^32 with no saturation. shd_rate is sign-extended to 32 bits.

Optional Feature:
- Macro: SAT_RAMP_EN.
- Defined: on every epoch_tick that does not apply a commit, freq[i] <= freq[i] + rate[i] for every satellite, provided primed = 1.
  - On a commit tick, freq loads the shadow value with no ramp added.
  - Ramping begins from the next tick.
- Undefined:
  - Ports are unchanged.
  - shd_rate is ignored and the rate registers are not synthesised.
  - freq changes only on commit.

Decomposition:
- Package gps_sched_pkg: FSM state enum (IDLE, ARMED), default NSAT, and width constants FREQ_W = 32, GAIN_W = 16, CASEL_W = 6, CNT_W = 16.
- One sub-module, gps_epoch_timer: cnt, epoch_tick and epoch_cnt, with the same clock/reset ports.

Test Plan:
- Reset mid-operation: with run = 1, freq[0] = 0x1234 and ARMED, assert axi_aresetn = 0 -> all outputs 0 immediately, state IDLE. After release, no tick until epoch_len + 1 cycles after run.
- Basic commit: epoch_len = 9, run = 1, shd_freq[0] = 0x00010000, commit_req at cycle 3.
  - First epoch_tick at cycle 10.
  - freq[0] = 0x00010000, commit_cnt = 1, gps_enable = 1 from cycle 11.
  - commit_busy high over cycles 4-10.
- Abort and overrun:
  - commit_req, then commit_req again -> commit_ovr = 1, still one commit.
  - commit_abort coincident with a tick -> outputs unchanged, commit_cnt unchanged.
- Same-cycle commit_req and tick in IDLE: epoch_len = 4 -> apply occurs at the next tick, 5 cycles later.
- Ramp wrap (SAT_RAMP_EN):
  - Commit freq[1] = 0xFFFFFFF0 with rate = +0x20 -> 0x00000010 after one further tick.
  - rate = -1 -> decrements by 1 per tick.
  - Without the macro, freq stays constant.
